bounce_position_counter: RTL and testbench

//  Registered position counter that steps one axis position per enabled cycle
//  and reverses at MIN_POS/MAX_POS walls; the direction bit is T-flip-flop state.

---
 rtl/bounce_position_counter.sv | 138 +++++++++++++
 tb/tb_bounce_position_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_position_counter.sv
// Bouncing axis position counter: steps between MIN_POS/MAX_POS walls with a T-flip-flop direction bit.
// Optional saturating wall-hit counter on BOUNCE_CNT when BOUNCE_COUNT_EN is defined.
module bounce_position_counter #(
    parameter int WIDTH     = 4,
    parameter int MIN_POS   = 0,
    parameter int MAX_POS   = 15,
    parameter int START_POS = 7,
    parameter int STEP      = 1
) (
    input  logic             CK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_POS,
    input  logic             LOAD_DIR,
    input  logic             FLIP,
    output logic [WIDTH-1:0] POS,
    output logic             DIR,
    output logic             AT_MIN,
    output logic             AT_MAX,
    output logic             BOUNCE
`ifdef BOUNCE_COUNT_EN
    ,
    output logic [7:0]       BOUNCE_CNT
`endif
);

    localparam logic [WIDTH:0]   MIN_W   = (WIDTH+1)'(MIN_POS);
    localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_POS);
    localparam logic [WIDTH:0]   STEP_W  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   ONE_W   = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MIN_P   = MIN_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_P   = MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] START_P = WIDTH'(START_POS);

    logic [WIDTH-1:0] pos_r;
    logic             dir_r;
    logic             bounce_r;

    logic [WIDTH:0]   pos_ext_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             dir_eff_s;
    logic [WIDTH-1:0] pos_nxt_s;
    logic             dir_nxt_s;
    logic             bounce_nxt_s;

    // Clamp a loaded position into the legal wall range; compare one bit wider to avoid wrap.
    function automatic logic [WIDTH-1:0] clamp_pos(input logic [WIDTH-1:0] p);
        logic [WIDTH:0]   p_ext;
        logic [WIDTH-1:0] r;
        p_ext = {1'b0, p};
        if (p_ext + ONE_W <= MIN_W) begin
            r = MIN_P;
        end else if (p_ext > MAX_W) begin
            r = MAX_P;
        end else begin
            r = p;
        end
        return r;
    endfunction

    // Next-state decode: LOAD overrides stepping; walls reverse in place and consume the step.
    always_comb begin
        pos_ext_s    = {1'b0, pos_r};
        sum_s        = pos_ext_s + STEP_W;
        diff_s       = pos_ext_s - STEP_W;
        dir_eff_s    = dir_r ^ FLIP;
        pos_nxt_s    = pos_r;
        dir_nxt_s    = dir_eff_s;
        bounce_nxt_s = 1'b0;
        if (LOAD) begin
            pos_nxt_s = clamp_pos(LOAD_POS);
            dir_nxt_s = LOAD_DIR;
        end else if (EN) begin
            if (dir_eff_s) begin
                if (sum_s >= MAX_W) begin
                    pos_nxt_s    = MAX_P;
                    dir_nxt_s    = 1'b0;
                    bounce_nxt_s = 1'b1;
                end else begin
                    pos_nxt_s = sum_s[WIDTH-1:0];
                    dir_nxt_s = 1'b1;
                end
            end else begin
                if (pos_ext_s <= MIN_W + STEP_W) begin
                    pos_nxt_s    = MIN_P;
                    dir_nxt_s    = 1'b1;
                    bounce_nxt_s = 1'b1;
                end else begin
                    pos_nxt_s = diff_s[WIDTH-1:0];
                    dir_nxt_s = 1'b0;
                end
            end
        end else begin
            pos_nxt_s = pos_r;
        end
    end

    // Position, direction and bounce pulse registers.
    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            pos_r    <= START_P;
            dir_r    <= 1'b1;
            bounce_r <= 1'b0;
        end else begin
            pos_r    <= pos_nxt_s;
            dir_r    <= dir_nxt_s;
            bounce_r <= bounce_nxt_s;
        end
    end

    assign POS    = pos_r;
    assign DIR    = dir_r;
    assign BOUNCE = bounce_r;
    assign AT_MIN = (pos_r == MIN_P);
    assign AT_MAX = (pos_r == MAX_P);

`ifdef BOUNCE_COUNT_EN
    logic [7:0] bounce_cnt_r;

    // Saturating count of wall reversals, cleared by reset and by LOAD.
    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            bounce_cnt_r <= 8'd0;
        end else if (LOAD) begin
            bounce_cnt_r <= 8'd0;
        end else if (bounce_nxt_s && (bounce_cnt_r != 8'd255)) begin
            bounce_cnt_r <= bounce_cnt_r + 8'd1;
        end else begin
            bounce_cnt_r <= bounce_cnt_r;
        end
    end

    assign BOUNCE_CNT = bounce_cnt_r;
`endif

endmodule

// File: tb/tb_bounce_position_counter.sv
// Bench for bounce_position_counter: three parameterisations share one stimulus stream,
// each checked every cycle against an integer model plus directed literal expectations.
module tb_bounce_position_counter;

    logic       CK       = 1'b0;
    logic       RESET    = 1'b1;
    logic       EN       = 1'b0;
    logic       LOAD     = 1'b0;
    logic [3:0] LOAD_POS = 4'd0;
    logic       LOAD_DIR = 1'b0;
    logic       FLIP     = 1'b0;

    always #5 CK = ~CK;

    logic [3:0] pos_w   [3];
    logic       dir_w   [3];
    logic       atmin_w [3];
    logic       atmax_w [3];
    logic       bnc_w   [3];
`ifdef BOUNCE_COUNT_EN
    logic [7:0] cnt_w   [3];
`endif

    // instance 0: defaults; instance 1: STEP=4; instance 2: MIN_POS=2
    bounce_position_counter #(.WIDTH(4), .MIN_POS(0), .MAX_POS(15), .START_POS(7), .STEP(1)) dut0 (
        .CK(CK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_POS(LOAD_POS), .LOAD_DIR(LOAD_DIR),
        .FLIP(FLIP), .POS(pos_w[0]), .DIR(dir_w[0]), .AT_MIN(atmin_w[0]), .AT_MAX(atmax_w[0]),
        .BOUNCE(bnc_w[0])
`ifdef BOUNCE_COUNT_EN
        , .BOUNCE_CNT(cnt_w[0])
`endif
    );
    bounce_position_counter #(.WIDTH(4), .MIN_POS(0), .MAX_POS(15), .START_POS(7), .STEP(4)) dut1 (
        .CK(CK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_POS(LOAD_POS), .LOAD_DIR(LOAD_DIR),
        .FLIP(FLIP), .POS(pos_w[1]), .DIR(dir_w[1]), .AT_MIN(atmin_w[1]), .AT_MAX(atmax_w[1]),
        .BOUNCE(bnc_w[1])
`ifdef BOUNCE_COUNT_EN
        , .BOUNCE_CNT(cnt_w[1])
`endif
    );
    bounce_position_counter #(.WIDTH(4), .MIN_POS(2), .MAX_POS(15), .START_POS(7), .STEP(1)) dut2 (
        .CK(CK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_POS(LOAD_POS), .LOAD_DIR(LOAD_DIR),
        .FLIP(FLIP), .POS(pos_w[2]), .DIR(dir_w[2]), .AT_MIN(atmin_w[2]), .AT_MAX(atmax_w[2]),
        .BOUNCE(bnc_w[2])
`ifdef BOUNCE_COUNT_EN
        , .BOUNCE_CNT(cnt_w[2])
`endif
    );

    int mn [3] = '{0, 0, 2};
    int st [3] = '{1, 4, 1};
    int mx     = 15;

    int m_pos [3];
    bit m_dir [3];
    bit m_bnc [3];
    int m_cnt [3];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int i);
        int lp;
        bit d;
        if (LOAD) begin
            lp       = int'(LOAD_POS);
            m_pos[i] = (lp < mn[i]) ? mn[i] : ((lp > mx) ? mx : lp);
            m_dir[i] = LOAD_DIR;
            m_bnc[i] = 1'b0;
            m_cnt[i] = 0;
        end else begin
            d        = m_dir[i] ^ FLIP;
            m_bnc[i] = 1'b0;
            if (!EN) begin
                m_dir[i] = d;
            end else if (d) begin
                if (m_pos[i] + st[i] >= mx) begin
                    m_pos[i] = mx; m_dir[i] = 1'b0; m_bnc[i] = 1'b1;
                end else begin
                    m_pos[i] = m_pos[i] + st[i]; m_dir[i] = 1'b1;
                end
            end else begin
                if (m_pos[i] <= mn[i] + st[i]) begin
                    m_pos[i] = mn[i]; m_dir[i] = 1'b1; m_bnc[i] = 1'b1;
                end else begin
                    m_pos[i] = m_pos[i] - st[i]; m_dir[i] = 1'b0;
                end
            end
            if (m_bnc[i] && m_cnt[i] < 255) m_cnt[i]++;
        end
    endtask

    always @(posedge CK or posedge RESET) begin
        for (int i = 0; i < 3; i++) begin
            if (RESET) begin
                m_pos[i] = 7; m_dir[i] = 1'b1; m_bnc[i] = 1'b0; m_cnt[i] = 0;
            end else begin
                model_edge(i);
            end
        end
    end

    always @(negedge CK) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_pos[%0d]", i), pos_w[i], m_pos[i]);
            chk($sformatf("model_dir[%0d]", i), dir_w[i], m_dir[i]);
            chk($sformatf("model_bounce[%0d]", i), bnc_w[i], m_bnc[i]);
            chk($sformatf("model_at_min[%0d]", i), atmin_w[i], (m_pos[i] == mn[i]) ? 1 : 0);
            chk($sformatf("model_at_max[%0d]", i), atmax_w[i], (m_pos[i] == mx) ? 1 : 0);
`ifdef BOUNCE_COUNT_EN
            chk($sformatf("model_cnt[%0d]", i), cnt_w[i], m_cnt[i]);
`endif
        end
    end

    task automatic step(input logic en, input logic flip, input logic load,
                        input logic [3:0] lp, input logic ld);
        EN = en; FLIP = flip; LOAD = load; LOAD_POS = lp; LOAD_DIR = ld;
        @(posedge CK);
        #1;
    endtask

    int exp_s4 [7] = '{11, 15, 11, 7, 3, 0, 4};

    initial begin
        repeat (2) @(posedge CK);
        #1;
        chk("reset_pos", pos_w[0], 7);
        chk("reset_dir", dir_w[0], 1);
        chk("reset_bounce", bnc_w[0], 0);
        RESET = 1'b0;

        // climb to the upper wall; STEP=4 instance runs its own bounce sequence
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
            if (k <= 8) chk("t1_pos", pos_w[0], 7 + k);
            if (k <= 8) chk("t1_bounce", bnc_w[0], (k == 8) ? 1 : 0);
            if (k == 8) begin
                chk("t1_dir_at_wall", dir_w[0], 0);
                chk("t1_at_max", atmax_w[0], 1);
            end
            if (k == 9) begin
                chk("t1_pos_after", pos_w[0], 14);
                chk("t1_bounce_after", bnc_w[0], 0);
            end
            if (k <= 7) begin
                chk("t2_pos", pos_w[1], exp_s4[k-1]);
                chk("t2_bounce", bnc_w[1], (k == 2 || k == 6) ? 1 : 0);
            end
            if (k == 6) chk("t2_dir_min", dir_w[1], 1);
        end

        // FLIP mid-field reverses without a bounce
        step(1'b0, 1'b0, 1'b1, 4'd9, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("t3_pos", pos_w[0], 8);
        chk("t3_dir", dir_w[0], 0);
        chk("t3_bounce", bnc_w[0], 0);

        // LOAD wins over EN/FLIP, then clamping to MIN_POS
        step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        chk("t4_load_pos", pos_w[0], 3);
        chk("t4_load_dir", dir_w[0], 0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t4_step_pos", pos_w[0], 2);
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        chk("t4_clamp_min2", pos_w[2], 2);
        chk("t4_load_zero", pos_w[0], 0);
        chk("t4_at_min", atmin_w[0], 1);

        // at wall heading outward: reverse in place
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("wall_out_pos", pos_w[0], 0);
        chk("wall_out_bounce", bnc_w[0], 1);
        chk("wall_out_dir", dir_w[0], 1);

        // FLIP at the upper wall: inward moves, outward bounces
        step(1'b0, 1'b0, 1'b1, 4'd15, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("flip_in_pos", pos_w[0], 14);
        chk("flip_in_bounce", bnc_w[0], 0);
        step(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("flip_out_pos", pos_w[0], 15);
        chk("flip_out_bounce", bnc_w[0], 1);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("en0_flip_dir", dir_w[0], 1);
        chk("en0_flip_pos", pos_w[0], 15);
        chk("en0_flip_bounce", bnc_w[0], 0);

        // asynchronous reset pulse between edges
        step(1'b0, 1'b0, 1'b1, 4'd12, 1'b0);
        #1 RESET = 1'b1;
        #1;
        chk("t5_async_pos", pos_w[0], 7);
        chk("t5_async_dir", dir_w[0], 1);
        chk("t5_async_bounce", bnc_w[0], 0);
        #1 RESET = 1'b0;
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t5_resume8", pos_w[0], 8);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("t5_resume9", pos_w[0], 9);

`ifdef BOUNCE_COUNT_EN
        step(1'b0, 1'b0, 1'b1, 4'd15, 1'b1);
        chk("t6_cnt_load", cnt_w[0], 0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("t6_cnt3", cnt_w[0], 3);
        step(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
        chk("t6_cnt_clear", cnt_w[0], 0);
        repeat (300) step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("t6_cnt_sat", cnt_w[0], 255);
`endif

        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge CK);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
